rc522_reg_sequencer: RTL

// - Turns single RC522 register read/write requests into the two-byte SPI sequence: address byte, then data byte.
// - Sits between the RC522 init/command step machine (upstream) and the 8-bit spi_master (downstream).
// - Drives spi_master start/data_in, follows busy_transaction, captures read data and flags timeouts.

---
 rtl/rc522_reg_sequencer_if.sv | 27 ++
 rtl/rc522_reg_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rc522_reg_sequencer_if.sv
// Request/response and spi_master signals of the RC522 register sequencer.
// slave = the sequencer's view; master = the environment (upstream step machine plus spi_master).
interface rc522_reg_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [5:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_mismatch;
    logic       spi_start_n;
    logic [7:0] spi_data_in;
    logic       spi_busy;
    logic [7:0] spi_data_out;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, spi_busy, spi_data_out,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_mismatch, spi_start_n, spi_data_in
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, spi_busy, spi_data_out,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_mismatch, spi_start_n, spi_data_in
    );
endinterface

// File: rtl/rc522_reg_sequencer.sv
// Turns one RC522 register read/write request into an address byte plus data byte on spi_master.
// Define RC522_VERIFY_EN to follow every completed write with an automatic readback of the same address.
module rc522_reg_sequencer #(
    parameter int unsigned START_PULSE_CYCLES = 1,
    parameter int unsigned GAP_CYCLES         = 4,
    parameter logic [27:0] TIMEOUT_CYCLES     = 28'd50000000
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    rc522_reg_sequencer_if.slave bus
);

    // state       | meaning
    // IDLE        | ready for a request
    // LOAD_x      | byte on spi_data_in, waiting for spi_busy=0
    // START_x     | spi_start_n low for START_PULSE_CYCLES
    // WAIT_RISE_x | waiting for busy=1;  WAIT_FALL_x: waiting for busy=0
    // GAP         | idle cycles between address and data byte
    // RESP        | rsp_valid pulse;  VERIFY: switch a finished write to its readback
    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_A,
        S_START_A,
        S_WAIT_RISE_A,
        S_WAIT_FALL_A,
        S_GAP,
        S_LOAD_D,
        S_START_D,
        S_WAIT_RISE_D,
        S_WAIT_FALL_D,
        S_RESP
`ifdef RC522_VERIFY_EN
        , S_VERIFY
`endif
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_is_read;
    logic [5:0]  r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_spi_data;
    logic [7:0]  r_pulse_cnt;
    logic [15:0] r_gap_cnt;
    logic [27:0] r_tmo;
    logic [7:0]  r_rsp_rdata;
    logic        r_rsp_err;
    logic        w_wait;
    logic        w_next_wait;
    logic        w_busy_done;
    logic        w_tmo_hit;
`ifdef RC522_VERIFY_EN
    logic        r_verify;
    logic        r_rsp_mismatch;
`endif

    assign w_wait      = (r_state == S_WAIT_RISE_A) || (r_state == S_WAIT_FALL_A) ||
                         (r_state == S_WAIT_RISE_D) || (r_state == S_WAIT_FALL_D);
    assign w_next_wait = (w_next == S_WAIT_RISE_A) || (w_next == S_WAIT_FALL_A) ||
                         (w_next == S_WAIT_RISE_D) || (w_next == S_WAIT_FALL_D);
    assign w_busy_done = (((r_state == S_WAIT_RISE_A) || (r_state == S_WAIT_RISE_D)) && bus.spi_busy) ||
                         (((r_state == S_WAIT_FALL_A) || (r_state == S_WAIT_FALL_D)) && !bus.spi_busy);
    // Busy arriving in the expiry cycle still counts as a normal completion.
    assign w_tmo_hit   = w_wait && !w_busy_done && (r_tmo == TIMEOUT_CYCLES - 28'd1);

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:        if (bus.req_valid) w_next = S_LOAD_A;
            S_LOAD_A:      if (!bus.spi_busy) w_next = S_START_A;
            S_START_A:     if (r_pulse_cnt == 8'd0) w_next = S_WAIT_RISE_A;
            S_WAIT_RISE_A: begin
                if (w_busy_done)    w_next = S_WAIT_FALL_A;
                else if (w_tmo_hit) w_next = S_RESP;
            end
            S_WAIT_FALL_A: begin
                if (w_busy_done)    w_next = (GAP_CYCLES == 0) ? S_LOAD_D : S_GAP;
                else if (w_tmo_hit) w_next = S_RESP;
            end
            S_GAP:         if (r_gap_cnt == 16'd0) w_next = S_LOAD_D;
            S_LOAD_D:      if (!bus.spi_busy) w_next = S_START_D;
            S_START_D:     if (r_pulse_cnt == 8'd0) w_next = S_WAIT_RISE_D;
            S_WAIT_RISE_D: begin
                if (w_busy_done)    w_next = S_WAIT_FALL_D;
                else if (w_tmo_hit) w_next = S_RESP;
            end
            S_WAIT_FALL_D: begin
                if (w_busy_done) begin
`ifdef RC522_VERIFY_EN
                    w_next = (!r_is_read && !r_verify) ? S_VERIFY : S_RESP;
`else
                    w_next = S_RESP;
`endif
                end else if (w_tmo_hit) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:        w_next = S_IDLE;
`ifdef RC522_VERIFY_EN
            S_VERIFY:      w_next = S_LOAD_A;
`endif
            default:       w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_is_read      <= 1'b0;
            r_addr         <= 6'd0;
            r_wdata        <= 8'd0;
            r_spi_data     <= 8'd0;
            r_pulse_cnt    <= 8'd0;
            r_gap_cnt      <= 16'd0;
            r_tmo          <= 28'd0;
            r_rsp_rdata    <= 8'd0;
            r_rsp_err      <= 1'b0;
`ifdef RC522_VERIFY_EN
            r_verify       <= 1'b0;
            r_rsp_mismatch <= 1'b0;
`endif
        end else begin
            if ((r_state == S_IDLE) && bus.req_valid) begin
                r_is_read  <= !bus.req_write;
                r_addr     <= bus.req_addr;
                r_wdata    <= bus.req_wdata;
                r_spi_data <= {!bus.req_write, bus.req_addr, 1'b0};
`ifdef RC522_VERIFY_EN
                r_verify   <= 1'b0;
`endif
            end
`ifdef RC522_VERIFY_EN
            if (r_state == S_VERIFY) begin
                r_is_read  <= 1'b1;
                r_verify   <= 1'b1;
                r_spi_data <= {1'b1, r_addr, 1'b0};
            end
`endif
            if ((w_next == S_LOAD_D) && (r_state != S_LOAD_D)) begin
                r_spi_data <= r_is_read ? 8'h00 : r_wdata;
            end

            if ((r_state == S_LOAD_A) || (r_state == S_LOAD_D)) begin
                r_pulse_cnt <= 8'(START_PULSE_CYCLES - 1);
            end else if (((r_state == S_START_A) || (r_state == S_START_D)) && (r_pulse_cnt != 8'd0)) begin
                r_pulse_cnt <= r_pulse_cnt - 8'd1;
            end

            if (r_state == S_WAIT_FALL_A) begin
                r_gap_cnt <= 16'(GAP_CYCLES - 1);
            end else if ((r_state == S_GAP) && (r_gap_cnt != 16'd0)) begin
                r_gap_cnt <= r_gap_cnt - 16'd1;
            end

            if (w_next_wait && (w_next != r_state)) begin
                r_tmo <= 28'd0;
            end else if (w_wait) begin
                r_tmo <= r_tmo + 28'd1;
            end

            // Response fields are only rewritten on the way into RESP, so they hold in between.
            if (w_next == S_RESP) begin
                r_rsp_err      <= w_tmo_hit;
                r_rsp_rdata    <= (!w_tmo_hit && r_is_read) ? bus.spi_data_out : 8'h00;
`ifdef RC522_VERIFY_EN
                r_rsp_mismatch <= !w_tmo_hit && r_verify && (bus.spi_data_out != r_wdata);
`endif
            end
        end
    end

    assign bus.req_ready   = (r_state == S_IDLE);
    assign bus.rsp_valid   = (r_state == S_RESP);
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.spi_start_n = !((r_state == S_START_A) || (r_state == S_START_D));
    assign bus.spi_data_in = r_spi_data;
`ifdef RC522_VERIFY_EN
    assign bus.rsp_mismatch = r_rsp_mismatch;
`else
    assign bus.rsp_mismatch = 1'b0;
`endif

endmodule
